// File: rtl/pulse_mon.sv
// pulse_mon: pulse-train monitor with UART frame reporter.
//
// Samples Pulse, Sync and P2, measures each Sync-to-Sync window (period,
// Sync->Pulse delay, first Pulse width, Pulse count) and ships each result
// as a fixed binary frame on RS232_Tx (8N1, LSB first, no inter-byte gap).
//
// Frame (bytes, fields MSB first):
//   A5 | period[4] | delay[4] | width[4] | (p2_width[4]) | count | xor
//
// Build option:
//   PULSE_MON_P2_EN  adds the P2 input lane and a 32-bit p2_width field,
//                    growing the frame from 15 to 19 bytes.
//
// Ports:
//   clk       system clock
//   resetn    async active-low reset
//   Pulse     async pulse input
//   Sync      async sync input, rising edges delimit windows
//   P2        async secondary pulse input (only used with PULSE_MON_P2_EN)
//   RS232_Tx  UART output, idle high
//   busy      frame transmission in progress
//   overrun   sticky, a window result was dropped while transmitting

// Per-lane input conditioner: 2-FF synchronizer plus registered edge strobes.
module pm_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);
  // sh[1:0] synchronize, sh[2] is the previous synchronized sample
  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sh   <= {sh[1:0], din};
      rise <= sh[1] & ~sh[2];
      fall <= ~sh[1] & sh[2];
    end
  end
endmodule

module pulse_mon #(
  parameter int CLK_DIV = 434,
  parameter int CNT_W   = 32
) (
  input  logic clk,
  input  logic resetn,
  input  logic Pulse,
  input  logic Sync,
  input  logic P2,
  output logic RS232_Tx,
  output logic busy,
  output logic overrun
);

`ifdef PULSE_MON_P2_EN
  localparam int NUM_LANES = 3;
  localparam int NB        = 19;
`else
  localparam int NUM_LANES = 2;
  localparam int NB        = 15;
`endif
  localparam int L_SYNC  = 0;
  localparam int L_PULSE = 1;
  localparam int NBW     = $clog2(NB);
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SAT      = '1;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] delay;
    logic [CNT_W-1:0] width;
`ifdef PULSE_MON_P2_EN
    logic [CNT_W-1:0] p2w;
`endif
    logic [7:0]       count;
  } res_t;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_st_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == SAT) ? x : x + CNT_W'(1);
  endfunction

  // ---------------- input lanes ----------------
  logic [NUM_LANES-1:0] pin_v, rise_v, fall_v;

`ifdef PULSE_MON_P2_EN
  localparam int L_P2 = 2;
  assign pin_v = {P2, Pulse, Sync};
`else
  assign pin_v = {Pulse, Sync};
  // P2 has no lane in this build; tie it off to a sink.
  logic unused_p2;
  assign unused_p2 = P2;
`endif

  pm_edge u_edge [NUM_LANES-1:0] (
    .clk  (clk),
    .rst_n(resetn),
    .din  (pin_v),
    .rise (rise_v),
    .fall (fall_v)
  );

  logic srise, prise, pfall;
  logic unused_sfall;
  assign srise        = rise_v[L_SYNC];
  assign prise        = rise_v[L_PULSE];
  assign pfall        = fall_v[L_PULSE];
  assign unused_sfall = fall_v[L_SYNC];

  // ---------------- window measurement ----------------
  logic             armed;
  logic [CNT_W-1:0] per_cnt, dly, wcnt, wid;
  logic             got_p, wact;
  logic [7:0]       cnt;
  logic             close;
  res_t             res;

  // The first Sync rise only arms; later rises close the current window.
  assign close = srise & armed;

`ifdef PULSE_MON_P2_EN
  logic             p2rise, p2fall, p2got, p2act;
  logic [CNT_W-1:0] p2cnt, p2wid;
  assign p2rise = rise_v[L_P2];
  assign p2fall = fall_v[L_P2];
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      armed   <= 1'b0;
      per_cnt <= '0;
      dly     <= SAT;
      got_p   <= 1'b0;
      wact    <= 1'b0;
      wcnt    <= '0;
      wid     <= SAT;
      cnt     <= '0;
`ifdef PULSE_MON_P2_EN
      p2got   <= 1'b0;
      p2act   <= 1'b0;
      p2cnt   <= '0;
      p2wid   <= SAT;
`endif
    end else if (srise) begin
      // New window. A pulse rise coincident with Sync belongs here (delay 0).
      armed   <= 1'b1;
      per_cnt <= CNT_W'(1);
      cnt     <= prise ? 8'd1 : 8'd0;
      got_p   <= prise;
      dly     <= prise ? '0 : SAT;
      wact    <= prise;
      wcnt    <= CNT_W'(1);
      wid     <= SAT;
`ifdef PULSE_MON_P2_EN
      p2got   <= p2rise;
      p2act   <= p2rise;
      p2cnt   <= CNT_W'(1);
      p2wid   <= SAT;
`endif
    end else if (armed) begin
      per_cnt <= sat_inc(per_cnt);
      if (prise) begin
        cnt <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
        if (!got_p) begin
          got_p <= 1'b1;
          dly   <= per_cnt;
          wact  <= 1'b1;
          wcnt  <= CNT_W'(1);
        end
      end
      if (wact) begin
        if (pfall) begin
          wid  <= wcnt;
          wact <= 1'b0;
        end else begin
          wcnt <= sat_inc(wcnt);
        end
      end
`ifdef PULSE_MON_P2_EN
      if (p2rise && !p2got) begin
        p2got <= 1'b1;
        p2act <= 1'b1;
        p2cnt <= CNT_W'(1);
      end
      if (p2act) begin
        if (p2fall) begin
          p2wid <= p2cnt;
          p2act <= 1'b0;
        end else begin
          p2cnt <= sat_inc(p2cnt);
        end
      end
`endif
    end
  end

  // Result as seen in the closing cycle; a width still open reads all-ones
  // unless its falling edge lands on this very cycle.
  always_comb begin
    res        = '0;
    res.period = per_cnt;
    res.delay  = dly;
    res.width  = wact ? (pfall ? wcnt : SAT) : wid;
`ifdef PULSE_MON_P2_EN
    res.p2w    = p2act ? (p2fall ? p2cnt : SAT) : p2wid;
`endif
    res.count  = cnt;
  end

  // ---------------- frame assembly ----------------
  // Byte k of the frame lives at index NB-1-k, so the struct order maps
  // straight onto the wire order.
  logic [NB-2:0][7:0] body;
  logic [7:0]         cs;
  logic [NB-1:0][7:0] frame_d, fbuf;

  assign body = {8'hA5, res};

  always_comb begin
    cs = 8'h00;
    for (int i = 0; i < NB - 1; i++) cs = cs ^ body[i];
  end

  assign frame_d = {body, cs};

  // ---------------- UART frame FSM ----------------
  tx_st_t           st, st_d;
  logic [DIV_W-1:0] div, div_d;
  logic [2:0]       bit_i, bit_d, bit_nx;
  logic [NBW-1:0]   byte_i, byte_d;
  logic             tx, tx_d, ld;
  logic [7:0]       cur;

  assign cur    = fbuf[byte_i];
  assign bit_nx = bit_i + 3'd1;

  always_comb begin
    st_d   = st;
    div_d  = div;
    bit_d  = bit_i;
    byte_d = byte_i;
    tx_d   = tx;
    ld     = 1'b0;
    case (st)
      IDLE: begin
        tx_d = 1'b1;
        if (close) begin
          ld     = 1'b1;
          st_d   = START;
          div_d  = DIV_LAST;
          byte_d = NBW'(NB - 1);
          tx_d   = 1'b0;
        end
      end
      START: begin
        if (div != '0) div_d = div - DIV_W'(1);
        else begin
          st_d  = DATA;
          div_d = DIV_LAST;
          bit_d = 3'd0;
          tx_d  = cur[0];
        end
      end
      DATA: begin
        if (div != '0) div_d = div - DIV_W'(1);
        else begin
          div_d = DIV_LAST;
          if (bit_i == 3'd7) begin
            st_d = STOP;
            tx_d = 1'b1;
          end else begin
            bit_d = bit_nx;
            tx_d  = cur[bit_nx];
          end
        end
      end
      STOP: begin
        if (div != '0) div_d = div - DIV_W'(1);
        else if (byte_i == '0) begin
          st_d = IDLE;
          tx_d = 1'b1;
        end else begin
          // Back-to-back: next byte goes straight into its start bit.
          byte_d = byte_i - NBW'(1);
          st_d   = START;
          div_d  = DIV_LAST;
          tx_d   = 1'b0;
        end
      end
      default: begin
        st_d = IDLE;
        tx_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st      <= IDLE;
      div     <= '0;
      bit_i   <= '0;
      byte_i  <= '0;
      tx      <= 1'b1;
      fbuf    <= '0;
      overrun <= 1'b0;
    end else begin
      st     <= st_d;
      div    <= div_d;
      bit_i  <= bit_d;
      byte_i <= byte_d;
      tx     <= tx_d;
      if (ld) fbuf <= frame_d;
      // The frame in flight is never touched; a result arriving now is lost.
      if (close && st != IDLE) overrun <= 1'b1;
    end
  end

  assign RS232_Tx = tx;
  assign busy     = (st != IDLE);

endmodule
